// File: rtl/dac_scan_seq_pkg.sv
// Shared types and constants for the DAC scan sequencer.
// Build option: DACSEQ_DBG_EN adds the dbg_rounds wrap counter.
package dac_scan_seq_pkg;

    localparam int unsigned BIT_PTR    = 5;
    localparam int unsigned N_DACV     = 18;
    localparam int unsigned SETTLE_W   = 4;
    localparam int unsigned CODE_W     = 8;
    localparam int unsigned SYNC_DEPTH = 2;
    // Counter holds settle_cyc plus the synchronizer latency.
    localparam int unsigned CNT_W      = SETTLE_W + 1;

    localparam logic [CODE_W-1:0] SAR_START = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEEK   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/dac_scan_seq_if.sv
// Sequencer <-> register bank / comparator signal bundle.
// Build option: DACSEQ_DBG_EN adds dbg_rounds.
interface dac_scan_seq_if;
    import dac_scan_seq_pkg::*;

    logic                scan_en;
    logic [SETTLE_W-1:0] settle_cyc;
    logic                comp_i;
    logic [N_DACV-1:0]   r_dac_en;
    logic [N_DACV-1:0]   r_sar_en;
    logic [BIT_PTR-1:0]  cs_ptr;
    logic                dacyc_done;
    logic                sync_i;
    logic [N_DACV-1:0]   v_upd;
    logic [CODE_W-1:0]   v_wdat;
    logic                sar_mode;
    logic [CODE_W-1:0]   sar_code;
    logic                busy;
`ifdef DACSEQ_DBG_EN
    logic [7:0]          dbg_rounds;

    modport master (
        input  scan_en, settle_cyc, comp_i, r_dac_en, r_sar_en,
        output cs_ptr, dacyc_done, sync_i, v_upd, v_wdat, sar_mode, sar_code, busy, dbg_rounds
    );
    modport slave (
        output scan_en, settle_cyc, comp_i, r_dac_en, r_sar_en,
        input  cs_ptr, dacyc_done, sync_i, v_upd, v_wdat, sar_mode, sar_code, busy, dbg_rounds
    );
`else
    modport master (
        input  scan_en, settle_cyc, comp_i, r_dac_en, r_sar_en,
        output cs_ptr, dacyc_done, sync_i, v_upd, v_wdat, sar_mode, sar_code, busy
    );
    modport slave (
        output scan_en, settle_cyc, comp_i, r_dac_en, r_sar_en,
        input  cs_ptr, dacyc_done, sync_i, v_upd, v_wdat, sar_mode, sar_code, busy
    );
`endif

endinterface

// File: rtl/dac_scan_seq_sar_step.sv
// SAR code register: trial code, bit index and keep/clear/next-bit step.
module dac_sar_step
    import dac_scan_seq_pkg::*;
(
    input  logic              clk,
    input  logic              srstz,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_bit_val,
    output logic [CODE_W-1:0] o_code,
    output logic              o_last_c,
    output logic [CODE_W-1:0] o_code_fin_c
);

    logic [CODE_W-1:0] r_code;
    logic [2:0]        r_bit;
    logic [CODE_W-1:0] w_bit_mask;

    // Current trial bit and the code after the comparator decision.
    always_comb begin
        w_bit_mask   = CODE_W'(1) << r_bit;
        o_last_c     = (r_bit == 3'd0);
        o_code_fin_c = i_bit_val ? r_code : (r_code & ~w_bit_mask);
    end

    // Load the start code, or resolve the current bit and try the next one.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) begin
            r_code <= '0;
            r_bit  <= '0;
        end else if (i_load) begin
            r_code <= SAR_START;
            r_bit  <= 3'd7;
        end else if (i_step) begin
            if (o_last_c) begin
                r_code <= o_code_fin_c;
            end else begin
                r_code <= o_code_fin_c | (w_bit_mask >> 1);
                r_bit  <= r_bit - 3'd1;
            end
        end
    end

    assign o_code = r_code;

endmodule

// File: rtl/dac_scan_seq.sv
// DAC scan sequencer: walks enabled channels, runs compare-only or 8-step SAR cycles.
// Build option: DACSEQ_DBG_EN adds a saturating pointer-wrap counter on dbg_rounds.
module dac_scan_seq
    import dac_scan_seq_pkg::*;
(
    input  logic           clk,
    input  logic           srstz,
    dac_scan_seq_if.master bus
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [SYNC_DEPTH-1:0] r_sync;
    logic [BIT_PTR-1:0]    r_cs_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_sar_lat;
    logic                  w_sar_lat_nxt;
    logic                  r_sar_mode;
    logic                  r_done;
    logic                  r_busy;
    logic [N_DACV-1:0]     r_v_upd;
    logic [CODE_W-1:0]     r_v_wdat;
    logic                  w_ptr_inc;
    logic                  w_ptr_last;
    logic [BIT_PTR-1:0]    w_ptr_nxt;
    logic                  w_any_en;
    logic                  w_ch_act;
    logic                  w_ch_sar;
    logic [CNT_W-1:0]      w_cnt_load;
    logic                  w_sar_load;
    logic                  w_sar_step;
    logic                  w_sar_last;
    logic [CODE_W-1:0]     w_sar_code;
    logic [CODE_W-1:0]     w_code_fin;

    assign w_any_en   = |bus.r_dac_en;
    assign w_ch_act   = bus.r_dac_en[r_cs_ptr];
    assign w_ch_sar   = bus.r_dac_en[r_cs_ptr] & bus.r_sar_en[r_cs_ptr];
    assign w_cnt_load = CNT_W'(bus.settle_cyc) + CNT_W'(SYNC_DEPTH);
    assign w_ptr_last = (r_cs_ptr == BIT_PTR'(N_DACV - 1));
    assign w_ptr_nxt  = w_ptr_last ? '0 : r_cs_ptr + BIT_PTR'(1);

    dac_sar_step u_sar_step (
        .clk          (clk),
        .srstz        (srstz),
        .i_load       (w_sar_load),
        .i_step       (w_sar_step),
        .i_bit_val    (r_sync[SYNC_DEPTH-1]),
        .o_code       (w_sar_code),
        .o_last_c     (w_sar_last),
        .o_code_fin_c (w_code_fin)
    );

    // State register.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, settle counter, pointer advance and SAR control.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_sar_lat_nxt = r_sar_lat;
        w_ptr_inc     = 1'b0;
        w_sar_load    = 1'b0;
        w_sar_step    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.scan_en && w_any_en) w_state_nxt = ST_SEEK;
            end
            ST_SEEK: begin
                if (!bus.scan_en || !w_any_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ch_act) begin
                    w_cnt_nxt     = w_cnt_load;
                    w_sar_lat_nxt = w_ch_sar;
                    w_sar_load    = w_ch_sar;
                    w_state_nxt   = ST_SETTLE;
                end else begin
                    w_ptr_inc = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!bus.scan_en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (!bus.scan_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_sar_lat) begin
                    w_sar_step = 1'b1;
                    if (w_sar_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt   = w_cnt_load;
                        w_state_nxt = ST_SETTLE;
                    end
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_ptr_inc   = 1'b1;
                w_state_nxt = (bus.scan_en && w_any_en) ? ST_SEEK : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Comparator synchronizer, free running.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_DEPTH-2:0], bus.comp_i};
    end

    // Datapath and registered strobes; strobes line up with the DONE state.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) begin
            r_cs_ptr   <= '0;
            r_cnt      <= '0;
            r_sar_lat  <= 1'b0;
            r_sar_mode <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_v_upd    <= '0;
            r_v_wdat   <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_sar_lat <= w_sar_lat_nxt;
            r_done    <= (w_state_nxt == ST_DONE);
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (w_ptr_inc) r_cs_ptr <= w_ptr_nxt;
            if (w_sar_load) begin
                r_sar_mode <= 1'b1;
            end else if (r_state == ST_DONE || w_state_nxt == ST_IDLE) begin
                r_sar_mode <= 1'b0;
            end
            if (w_sar_step && w_sar_last && w_state_nxt == ST_DONE) begin
                r_v_upd  <= N_DACV'(1) << r_cs_ptr;
                r_v_wdat <= w_code_fin;
            end else begin
                r_v_upd  <= '0;
            end
        end
    end

`ifdef DACSEQ_DBG_EN
    logic [7:0] r_dbg_rounds;

    // Saturating count of pointer wraps from the last channel back to 0.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) begin
            r_dbg_rounds <= '0;
        end else if (w_ptr_inc && w_ptr_last && r_dbg_rounds != 8'hFF) begin
            r_dbg_rounds <= r_dbg_rounds + 8'd1;
        end
    end

    assign bus.dbg_rounds = r_dbg_rounds;
`endif

    assign bus.cs_ptr     = r_cs_ptr;
    assign bus.dacyc_done = r_done;
    assign bus.sync_i     = r_sync[SYNC_DEPTH-1];
    assign bus.v_upd      = r_v_upd;
    assign bus.v_wdat     = r_v_wdat;
    assign bus.sar_mode   = r_sar_mode;
    assign bus.sar_code   = w_sar_code;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_dac_scan_seq.sv
// Scoreboard bench for dac_scan_seq: expected end-of-cycle events are queued
// when a scan is launched and matched against each dacyc_done strobe.
module tb_dac_scan_seq;

    logic clk = 1'b0;
    logic srstz = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_done = 0;
    bit mon_en = 1'b1;

    // Comparator model: forced level, or an analog input compared with the trial code.
    bit         cmp_force = 1'b1;
    logic       comp_lvl = 1'b0;
    logic [7:0] analog = 8'h00;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  ptr;
        logic [17:0] upd;
        logic [7:0]  wdat;
        bit          chk_wdat;
        bit          chk_sync;
        logic        sync;
    } exp_t;

    exp_t sb_q[$];

    dac_scan_seq_if bus();

    dac_scan_seq u_dut (
        .clk   (clk),
        .srstz (srstz),
        .bus   (bus)
    );

    // Comparator reads high when analog is at or above the trial code,
    // so the SAR search lands exactly on the analog value.
    assign bus.comp_i = cmp_force ? comp_lvl : (analog >= bus.sar_code);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int unsigned c, input int unsigned p, input logic [17:0] u,
                            input logic [7:0] w, input bit cw, input bit cs, input logic s);
        exp_t e;
        e.cyc = c; e.ptr = 5'(p); e.upd = u; e.wdat = w;
        e.chk_wdat = cw; e.chk_sync = cs; e.sync = s;
        sb_q.push_back(e);
    endtask

    // Advance to the falling edge inside cycle t.
    task automatic at_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        srstz = 1'b0;
        @(negedge clk);
        srstz = 1'b1;
    endtask

    // Match every strobe against the scoreboard head; flag strays.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (mon_en) begin
            if (bus.dacyc_done) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    chk("done_unexpected", 32'(bus.cs_ptr), 32'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_ptr", 32'(bus.cs_ptr), 32'(e.ptr));
                    chk("done_vupd", 32'(bus.v_upd), 32'(e.upd));
                    if (e.chk_wdat) chk("done_wdat", 32'(bus.v_wdat), 32'(e.wdat));
                    if (e.chk_sync) chk("done_sync", 32'(bus.sync_i), 32'(e.sync));
                end
            end else if (bus.v_upd != '0) begin
                chk("vupd_without_done", 32'(bus.v_upd), 32'h0);
            end
            if ($countones(bus.v_upd) > 1) chk("vupd_onehot", 32'(bus.v_upd), 32'h0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned e0;
        int unsigned nd;
        bus.scan_en    = 1'b0;
        bus.settle_cyc = '0;
        bus.r_dac_en   = '0;
        bus.r_sar_en   = '0;
        comp_lvl       = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values while srstz is held low with comp_i high.
        chk("rst_cs_ptr", 32'(bus.cs_ptr), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.dacyc_done), 32'h0);
        chk("rst_sync", 32'(bus.sync_i), 32'h0);
        chk("rst_sar_mode", 32'(bus.sar_mode), 32'h0);
        chk("rst_sar_code", 32'(bus.sar_code), 32'h0);
        chk("rst_vupd", 32'(bus.v_upd), 32'h0);
        srstz = 1'b1;
        repeat (3) @(negedge clk);

        // A: compare-only ch0 and ch2, settle 3; ch1 costs one SEEK cycle.
        bus.settle_cyc = 4'd3;
        bus.r_dac_en   = 18'h00005;
        bus.scan_en    = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 7,  0, 18'h0, 8'h0, 1'b0, 1'b1, 1'b1);
        push_exp(e0 + 16, 2, 18'h0, 8'h0, 1'b0, 1'b1, 1'b1);
        at_cyc(e0 + 18);
        chk("A_drained", sb_q.size(), 0);
        bus.scan_en = 1'b0;
        at_cyc(e0 + 20);
        chk("A_idle_busy", 32'(bus.busy), 32'h0);

        // B: SAR on ch2, analog 5A then C3 on the revisit.
        do_reset();
        cmp_force      = 1'b0;
        analog         = 8'h5A;
        bus.settle_cyc = 4'd2;
        bus.r_dac_en   = 18'h00004;
        bus.r_sar_en   = 18'h00004;
        bus.scan_en    = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 43,  2, 18'h00004, 8'h5A, 1'b1, 1'b0, 1'b0);
        push_exp(e0 + 102, 2, 18'h00004, 8'hC3, 1'b1, 1'b0, 1'b0);
        at_cyc(e0 + 3);
        chk("B_sar_mode", 32'(bus.sar_mode), 32'h1);
        chk("B_sar_start", 32'(bus.sar_code), 32'h80);
        at_cyc(e0 + 44);
        analog = 8'hC3;
        at_cyc(e0 + 103);
        chk("B_drained", sb_q.size(), 0);
        bus.scan_en = 1'b0;

        // C: only ch17, settle 0; pointer wraps 17 -> 0 -> ... -> 17.
        do_reset();
        cmp_force      = 1'b1;
        comp_lvl       = 1'b0;
        bus.settle_cyc = 4'd0;
        bus.r_dac_en   = 18'h20000;
        bus.r_sar_en   = '0;
        bus.scan_en    = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 21, 17, 18'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        push_exp(e0 + 43, 17, 18'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        at_cyc(e0 + 22);
        chk("C_wrap_ptr0", 32'(bus.cs_ptr), 32'h0);
`ifdef DACSEQ_DBG_EN
        chk("C_dbg_1", 32'(bus.dbg_rounds), 32'h1);
`endif
        at_cyc(e0 + 39);
        chk("C_ptr17", 32'(bus.cs_ptr), 32'd17);
        at_cyc(e0 + 44);
        chk("C_drained", sb_q.size(), 0);
`ifdef DACSEQ_DBG_EN
        chk("C_dbg_2", 32'(bus.dbg_rounds), 32'h2);
        mon_en = 1'b0;
        at_cyc(e0 + 22 * 258 + 5);
        chk("C_dbg_sat", 32'(bus.dbg_rounds), 32'hFF);
`endif
        bus.scan_en = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // D: scan_en dropped during SETTLE of a SAR channel.
        do_reset();
        cmp_force      = 1'b0;
        bus.settle_cyc = 4'd5;
        bus.r_dac_en   = 18'h00001;
        bus.r_sar_en   = 18'h00001;
        bus.scan_en    = 1'b1;
        e0 = cyc + 1;
        nd = n_done;
        at_cyc(e0 + 2);
        chk("D_sar_mode_on", 32'(bus.sar_mode), 32'h1);
        bus.scan_en = 1'b0;
        at_cyc(e0 + 3);
        chk("D_busy_off", 32'(bus.busy), 32'h0);
        chk("D_sar_mode_off", 32'(bus.sar_mode), 32'h0);
        chk("D_ptr_kept", 32'(bus.cs_ptr), 32'h0);
        at_cyc(e0 + 15);
        chk("D_no_done", n_done - nd, 0);

        // E: r_sar_en cleared mid-SAR; SAR still completes, next visit compare-only.
        do_reset();
        analog         = 8'h37;
        bus.settle_cyc = 4'd1;
        bus.r_dac_en   = 18'h00002;
        bus.r_sar_en   = 18'h00002;
        bus.scan_en    = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 34, 1, 18'h00002, 8'h37, 1'b1, 1'b0, 1'b0);
        push_exp(e0 + 57, 1, 18'h0,     8'h37, 1'b1, 1'b1, 1'b1);
        at_cyc(e0 + 10);
        bus.r_sar_en = '0;
        at_cyc(e0 + 54);
        chk("E_cmp_sar_mode", 32'(bus.sar_mode), 32'h0);
        at_cyc(e0 + 58);
        chk("E_drained", sb_q.size(), 0);
        bus.scan_en = 1'b0;
        repeat (3) @(negedge clk);

        // F: asynchronous reset in the middle of a SAR conversion.
        analog         = 8'hA5;
        bus.settle_cyc = 4'd3;
        bus.r_dac_en   = 18'h00004;
        bus.r_sar_en   = 18'h00004;
        bus.scan_en    = 1'b1;
        at_cyc(cyc + 12);
        chk("F_pre_wdat", 32'(bus.v_wdat), 32'h37);
        #2;
        srstz = 1'b0;
        #1;
        chk("F_rst_busy", 32'(bus.busy), 32'h0);
        chk("F_rst_sar_mode", 32'(bus.sar_mode), 32'h0);
        chk("F_rst_sar_code", 32'(bus.sar_code), 32'h0);
        chk("F_rst_ptr", 32'(bus.cs_ptr), 32'h0);
        chk("F_rst_wdat", 32'(bus.v_wdat), 32'h0);
        chk("F_rst_sync", 32'(bus.sync_i), 32'h0);
        @(negedge clk);
        srstz = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 51, 2, 18'h00004, 8'hA5, 1'b1, 1'b0, 1'b0);
        at_cyc(e0);
        chk("F_restart_ptr", 32'(bus.cs_ptr), 32'h0);
        chk("F_restart_busy", 32'(bus.busy), 32'h1);
        at_cyc(e0 + 53);
        chk("F_drained", sb_q.size(), 0);
        bus.scan_en = 1'b0;
        repeat (3) @(negedge clk);

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
